// File: rtl/soc_mem_pkg.sv
// Shared constants and helpers for the SoC memory responder.
// Holds the config-window defaults, register offsets, reset values
// and the byte-merge helper used by both the RAM and the config registers.
package soc_mem_pkg;

   localparam logic [31:0] CONF_BASE_DEF = 32'hBFAF_0000;
   localparam logic [31:0] CONF_MASK_DEF = 32'hFFFF_0000;

   localparam logic [15:0] LED_OFF    = 16'hF000;
   localparam logic [15:0] NUM_OFF    = 16'hF010;
   localparam logic [15:0] TIMER_OFF  = 16'hE000;
   localparam logic [15:0] SWITCH_OFF = 16'hF020;

   localparam logic [15:0] LED_RST   = 16'hFFFF;
   localparam logic [31:0] NUM_RST   = 32'h0000_0000;
   localparam logic [31:0] TIMER_RST = 32'h0000_0000;

   // Replace each byte of old_v whose enable bit is set with the byte of new_v.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  we);
      logic [31:0] res;
      res = old_v;
      for (int i = 0; i < 4; i++) begin
         if (we[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/soc_confreg.sv
// Config register file: LED, NUM, free-running TIMER and read-only SWITCH.
// Read data is registered in the request cycle, matching the RAM latency,
// and reflects register values before any same-cycle update.
module soc_confreg
   import soc_mem_pkg::*;
(
   input  logic        clk,
   input  logic        reset_i,
   input  logic        en_i,
   input  logic [3:0]  we_i,
   input  logic [15:0] off_i,
   input  logic [31:0] wdata_i,
   input  logic [7:0]  switch_i,
   output logic [31:0] rdata_o,
   output logic [15:0] led_o,
   output logic [31:0] num_o
);

   logic [15:0] led_q, led_d;
   logic [31:0] num_q, num_d;
   logic [31:0] timer_q, timer_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] rd_mux;
   logic        wr_req;
   logic        rd_req;

   assign wr_req = en_i && (we_i != 4'h0);
   assign rd_req = en_i && (we_i == 4'h0);

   // Read mux over current register values; unmapped offsets return zero.
   always_comb begin
      rd_mux = 32'h0;
      case (off_i)
         LED_OFF:    rd_mux = {16'h0, led_q};
         NUM_OFF:    rd_mux = num_q;
         TIMER_OFF:  rd_mux = timer_q;
         SWITCH_OFF: rd_mux = {24'h0, switch_i};
         default:    rd_mux = 32'h0;
      endcase
   end

   // Next-state: byte-merged writes, timer increments unless being loaded.
   always_comb begin
      led_d   = led_q;
      num_d   = num_q;
      timer_d = timer_q + 32'd1;
      rdata_d = rdata_q;
      if (wr_req) begin
         case (off_i)
            LED_OFF:   led_d   = 16'(byte_merge({16'h0, led_q}, wdata_i, we_i));
            NUM_OFF:   num_d   = byte_merge(num_q, wdata_i, we_i);
            TIMER_OFF: timer_d = byte_merge(timer_q, wdata_i, we_i);
            default:   ;
         endcase
      end
      if (rd_req) rdata_d = rd_mux;
   end

   // Register update with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset_i) begin
         led_q   <= LED_RST;
         num_q   <= NUM_RST;
         timer_q <= TIMER_RST;
         rdata_q <= 32'h0;
      end else begin
         led_q   <= led_d;
         num_q   <= num_d;
         timer_q <= timer_d;
         rdata_q <= rdata_d;
      end
   end

   assign rdata_o = rdata_q;
   assign led_o   = led_q;
   assign num_o   = num_q;

endmodule

// File: rtl/soc_sram_responder.sv
// Dual-port word RAM with byte enables and 1-cycle registered reads,
// answering the CPU inst_sram and data_sram ports.
// Build option SOC_CONFREG_EN: when defined, data-port accesses in the
// config window go to soc_confreg instead of the RAM; when undefined,
// every access goes to the RAM and led/num_data are tied to reset values.
module soc_sram_responder
   import soc_mem_pkg::*;
#(
   parameter int          ADDR_W    = 16,
   parameter logic [31:0] CONF_BASE = CONF_BASE_DEF,
   parameter logic [31:0] CONF_MASK = CONF_MASK_DEF
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_sram_en,
   input  logic [3:0]  inst_sram_we,
   input  logic [31:0] inst_sram_addr,
   input  logic [31:0] inst_sram_wdata,
   output logic [31:0] inst_sram_rdata,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_we,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   input  logic [7:0]  switch,
   output logic [15:0] led,
   output logic [31:0] num_data
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [ADDR_W-1:0] inst_idx;
   logic [ADDR_W-1:0] data_idx;
   logic              conf_hit;
   logic              ram_d_en;
   logic              i_wr, i_rd, d_wr, d_rd;
   logic [31:0]       inst_ram_rd;
   logic [31:0]       data_ram_rd;
   logic              unused_bits;

   assign inst_idx = inst_sram_addr[ADDR_W+1:2];
   assign data_idx = data_sram_addr[ADDR_W+1:2];

   // Address bits above the word index and below word alignment are ignored.
   assign unused_bits = ^{inst_sram_addr, data_sram_addr, switch};

`ifdef SOC_CONFREG_EN
   assign conf_hit = ((data_sram_addr & CONF_MASK) == CONF_BASE);
`else
   assign conf_hit = 1'b0;
`endif

   // A config hit removes the data-port access from the RAM entirely.
   assign ram_d_en = data_sram_en && !conf_hit;
   assign i_wr     = inst_sram_en && (inst_sram_we != 4'h0);
   assign i_rd     = inst_sram_en && (inst_sram_we == 4'h0);
   assign d_wr     = ram_d_en && (data_sram_we != 4'h0);
   assign d_rd     = ram_d_en && (data_sram_we == 4'h0);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem_q [DEPTH];
         logic [7:0] i_rd_q;
         logic [7:0] d_rd_q;

         // Byte-lane writes; the data port is applied last so it wins collisions.
         // Not reset, so a write issued during reset still lands.
         always_ff @(posedge clk) begin
            if (i_wr && inst_sram_we[gi]) mem_q[inst_idx] <= inst_sram_wdata[gi*8 +: 8];
            if (d_wr && data_sram_we[gi]) mem_q[data_idx] <= data_sram_wdata[gi*8 +: 8];
         end

         // Read-first registered reads; hold previous value when not reading.
         always_ff @(posedge clk) begin
            if (reset) begin
               i_rd_q <= 8'h0;
               d_rd_q <= 8'h0;
            end else begin
               if (i_rd) i_rd_q <= mem_q[inst_idx];
               if (d_rd) d_rd_q <= mem_q[data_idx];
            end
         end

         assign inst_ram_rd[gi*8 +: 8] = i_rd_q;
         assign data_ram_rd[gi*8 +: 8] = d_rd_q;
      end
   endgenerate

   assign inst_sram_rdata = inst_ram_rd;

`ifdef SOC_CONFREG_EN
   logic [31:0] conf_rdata;
   logic        sel_conf_q;

   soc_confreg u_confreg (
      .clk      (clk),
      .reset_i  (reset),
      .en_i     (data_sram_en && conf_hit),
      .we_i     (data_sram_we),
      .off_i    (data_sram_addr[15:0]),
      .wdata_i  (data_sram_wdata),
      .switch_i (switch),
      .rdata_o  (conf_rdata),
      .led_o    (led),
      .num_o    (num_data)
   );

   // Remember which source answered the last data-port read.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel_conf_q <= 1'b0;
      end else if (data_sram_en && (data_sram_we == 4'h0)) begin
         sel_conf_q <= conf_hit;
      end
   end

   assign data_sram_rdata = sel_conf_q ? conf_rdata : data_ram_rd;
`else
   assign led             = LED_RST;
   assign num_data        = NUM_RST;
   assign data_sram_rdata = data_ram_rd;
`endif

endmodule
